fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter IMEM_AW, default 20, instruction-memory word-address width (16-bit words).
REQ-002 SHALL have ports clk  in  1  rising-edge clock; rst  in  1  asynchronous active-low reset (rst=0 resets).
REQ-003 SHALL have ports pc_in  in  32  current PC from PC mux; imem_rdata  in  16  combinational instruction-memory read data.
REQ-004 SHALL have ports stall  in  1  hold IF/ID; flush  in  1  squash fetch in progress.
REQ-005 SHALL have ports imem_addr  out  IMEM_AW  memory address; next_pc  out  32  sequential address fed back to PC mux.
REQ-006 SHALL have port pc_enable  out  1  PC mux update enable.
REQ-007 SHALL have ports id_valid  out  1; id_instr  out  16; id_imm  out  16; id_pc_plus  out  32  (IF/ID register outputs).

Function
REQ-008 SHALL drive imem_addr = pc_in[IMEM_AW-1:0] and next_pc = pc_in + 1 combinationally, 32-bit wrap (0xFFFFFFFF -> 0x00000000).
REQ-009 SHALL treat imem_rdata[15]=1 as a two-word instruction (16-bit immediate in the following word), else one-word.
REQ-010 SHALL implement states FETCH and IMM; reset state FETCH.
REQ-011 In FETCH, not stalled, not flushed, one-word: SHALL load id_instr=imem_rdata, id_imm=0, id_pc_plus=pc_in+1, id_valid=1; stay FETCH.
REQ-012 In FETCH, not stalled, not flushed, two-word: SHALL latch imem_rdata into an internal hold register, set id_valid=0, go IMM.
REQ-013 In IMM, not stalled, not flushed: SHALL load id_instr=hold, id_imm=imem_rdata, id_pc_plus=pc_in+1, id_valid=1; go FETCH.
REQ-014 SHALL drive pc_enable = ~stall | flush, so the PC advances every unstalled cycle, including the first word of a two-word instruction.
REQ-015 On stall=1, flush=0: SHALL hold state, the hold register and all id_* outputs unchanged.
REQ-016 On flush=1: SHALL set id_valid=0, go FETCH, discard hold, and leave id_instr/id_imm/id_pc_plus unchanged; flush SHALL override stall in the same cycle.
REQ-017 A flush arriving in IMM SHALL abandon the partial two-word instruction; no id_valid pulse SHALL occur for it.
REQ-018 Latency: one-word instruction SHALL appear on id_* one clock after its address is on pc_in; two-word SHALL appear one clock after the immediate address.

Reset
REQ-019 While rst=0: state=FETCH, hold=0, id_valid=0, id_instr=0, id_imm=0, id_pc_plus=0, effective asynchronously.
REQ-020 Reset mid-IMM SHALL discard the partial instruction; first edge after release SHALL behave as FETCH.
REQ-021 Combinational outputs (imem_addr, next_pc, pc_enable) SHALL follow their inputs during reset.

Configuration
REQ-022 With FETCH_PERF_CNT_EN defined: SHALL add outputs perf_instr_cnt  out  32 (increments on each id_valid=1 load) and perf_bubble_cnt  out  32 (increments each cycle that clocks id_valid=0 without stall, including flushes), both reset to 0, wrapping at 2^32.
REQ-023 Without FETCH_PERF_CNT_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-024 Release reset, pc_in=0x20, imem_rdata=0x1234 -> next clock id_valid=1, id_instr=0x1234, id_imm=0, id_pc_plus=0x21.
REQ-025 pc_in=0x40 rdata=0x8005, then pc_in=0x41 rdata=0xBEEF -> id_valid 0 then 1, id_instr=0x8005, id_imm=0xBEEF, id_pc_plus=0x42; pc_enable=1 both cycles.
REQ-026 stall=1 for 3 cycles after loading 0x1234 -> id_* unchanged, pc_enable=0; stall and flush both 1 -> id_valid=0, pc_enable=1.
REQ-027 Two-word first word 0x8001 then flush=1 in IMM -> id_valid stays 0, state FETCH; next word 0x0007 emitted as one-word.
REQ-028 rst=0 asserted between clock edges while in IMM -> id_valid=0, id_instr=0 immediately; pc_in=0xFFFFFFFF -> next_pc=0x00000000.
REQ-029 With FETCH_PERF_CNT_EN: 2 one-word, 1 two-word, 1 flush -> perf_instr_cnt=3, perf_bubble_cnt=2.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for a 16-bit instruction set with optional two-word
// instructions (bit 15 of the first word set means a 16-bit immediate follows
// in the next word). Produces the instruction-memory address and the
// sequential next PC combinationally. It also owns the IF/ID pipeline register.
//
// Parameters
//   IMEM_AW          instruction-memory word-address width (16-bit words)
//
// Configuration macro
//   FETCH_PERF_CNT_EN  when defined, adds perf_instr_cnt / perf_bubble_cnt
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   pc_in[31:0]      current PC from the PC mux
//   imem_rdata[15:0] combinational instruction-memory read data
//   stall            hold the IF/ID register and fetch state
//   flush            squash the fetch in progress (overrides stall)
//   imem_addr        instruction-memory word address (pc_in low bits)
//   next_pc[31:0]    pc_in + 1, fed back to the PC mux
//   pc_enable        PC mux update enable
//   id_valid         IF/ID register holds a complete instruction
//   id_instr[15:0]   instruction word (first word for two-word forms)
//   id_imm[15:0]     immediate word (zero for one-word instructions)
//   id_pc_plus[31:0] address following the last word of the instruction
//   dbg_state        fetch FSM state (0 = FETCH, 1 = IMM)
//   perf_instr_cnt   (optional) count of id_valid=1 loads
//   perf_bubble_cnt  (optional) count of unstalled edges loading id_valid=0
//
// Handshake: there is no backpressure handshake on the IF/ID register; stall
// freezes everything, and flush drops any partial or presented instruction.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int IMEM_AW = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_in,
  input  logic [15:0]        imem_rdata,
  input  logic               stall,
  input  logic               flush,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        next_pc,
  output logic               pc_enable,
  output logic               id_valid,
  output logic [15:0]        id_instr,
  output logic [15:0]        id_imm,
  output logic [31:0]        id_pc_plus,
  output logic               dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_instr_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_IMM   = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_hold;
  logic        r_id_valid;
  logic [15:0] r_id_instr;
  logic [15:0] r_id_imm;
  logic [31:0] r_id_pc_plus;

  logic [31:0] w_pc_plus;
  logic        w_two_word;
  logic        w_advance;
  logic        w_load_valid;

  assign w_pc_plus  = pc_in + 32'd1;
  assign w_two_word = imem_rdata[15];
  assign w_advance  = ~stall & ~flush;
  // A complete instruction lands in IF/ID on this edge.
  assign w_load_valid = w_advance & ((r_state == S_IMM) | ~w_two_word);

  assign imem_addr = pc_in[IMEM_AW-1:0];
  assign next_pc   = w_pc_plus;
  // The PC keeps moving on the first word of a two-word instruction so the
  // immediate is fetched on the very next cycle.
  assign pc_enable = ~stall | flush;

  assign id_valid   = r_id_valid;
  assign id_instr   = r_id_instr;
  assign id_imm     = r_id_imm;
  assign id_pc_plus = r_id_pc_plus;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_FETCH;
      r_hold       <= 16'd0;
      r_id_valid   <= 1'b0;
      r_id_instr   <= 16'd0;
      r_id_imm     <= 16'd0;
      r_id_pc_plus <= 32'd0;
    end else if (flush) begin
      // Payload fields are left alone; only validity and the partial
      // instruction are dropped.
      r_state    <= S_FETCH;
      r_hold     <= 16'd0;
      r_id_valid <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        S_FETCH: begin
          if (w_two_word) begin
            r_hold     <= imem_rdata;
            r_id_valid <= 1'b0;
            r_state    <= S_IMM;
          end else begin
            r_id_instr   <= imem_rdata;
            r_id_imm     <= 16'd0;
            r_id_pc_plus <= w_pc_plus;
            r_id_valid   <= 1'b1;
            r_state      <= S_FETCH;
          end
        end
        S_IMM: begin
          r_id_instr   <= r_hold;
          r_id_imm     <= imem_rdata;
          r_id_pc_plus <= w_pc_plus;
          r_id_valid   <= 1'b1;
          r_state      <= S_FETCH;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_instr_cnt;
  logic [31:0] r_perf_bubble_cnt;
  logic        w_load_bubble;

  // Any unstalled edge that leaves id_valid low, flushes included.
  assign w_load_bubble = flush | (w_advance & ~w_load_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_instr_cnt  <= 32'd0;
      r_perf_bubble_cnt <= 32'd0;
    end else begin
      if (w_load_valid) begin
        r_perf_instr_cnt <= r_perf_instr_cnt + 32'd1;
      end
      if (w_load_bubble) begin
        r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
      end
    end
  end

  assign perf_instr_cnt  = r_perf_instr_cnt;
  assign perf_bubble_cnt = r_perf_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int IMEM_AW = 20;

  // ---------------------------------------------------------------- clock/reset
  logic               clk;
  logic               rst;
  logic [31:0]        pc_in;
  logic [15:0]        imem_rdata;
  logic               stall;
  logic               flush;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        next_pc;
  logic               pc_enable;
  logic               id_valid;
  logic [15:0]        id_instr;
  logic [15:0]        id_imm;
  logic [31:0]        id_pc_plus;
  logic               dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        perf_instr_cnt;
  logic [31:0]        perf_bubble_cnt;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fetch_unit #(.IMEM_AW(IMEM_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .flush      (flush),
    .imem_addr  (imem_addr),
    .next_pc    (next_pc),
    .pc_enable  (pc_enable),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_imm     (id_imm),
    .id_pc_plus (id_pc_plus),
    .dbg_state  (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_instr_cnt  (perf_instr_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  // ---------------------------------------------------------------- counters
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  // Entry = {instr, imm, pc_plus}
  logic [63:0] exp_q[$];
  logic        edge_loaded;

  // Remember whether the last edge was a loading edge (no stall, no flush).
  always @(posedge clk) begin
    edge_loaded <= rst & ~stall & ~flush;
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst && id_valid && edge_loaded) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_instr: got instr=0x%04h imm=0x%04h pcp=0x%08h expected none",
                 id_instr, id_imm, id_pc_plus);
      end else begin
        e = exp_q.pop_front();
        if ({id_instr, id_imm, id_pc_plus} !== e) begin
          n_fail++;
          $display("FAIL id_out: got instr=0x%04h imm=0x%04h pcp=0x%08h expected instr=0x%04h imm=0x%04h pcp=0x%08h",
                   id_instr, id_imm, id_pc_plus, e[63:48], e[47:32], e[31:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [15:0] rd,
                       input logic st, input logic fl);
    pc_in      = pc;
    imem_rdata = rd;
    stall      = st;
    flush      = fl;
  endtask

  task automatic expect_instr(input logic [15:0] ins, input logic [15:0] imm,
                              input logic [31:0] pcp);
    exp_q.push_back({ins, imm, pcp});
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b0;
    drive(32'h0, 16'h0, 1'b0, 1'b0);
    tick();
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", {16'd0, id_instr}, 32'd0);
    chk("rst_imm",   {16'd0, id_imm}, 32'd0);
    chk("rst_pcp",   id_pc_plus, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);
    rst = 1'b1;

    // One-word fetch
    drive(32'h20, 16'h1234, 1'b0, 1'b0);
    #1;
    chk("imem_addr", {12'd0, imem_addr}, 32'h20);
    chk("next_pc",   next_pc, 32'h21);
    chk("pc_en_run", {31'd0, pc_enable}, 32'd1);
    expect_instr(16'h1234, 16'h0000, 32'h21);
    tick();

    // Stall three cycles: IF/ID frozen, PC held
    drive(32'h21, 16'h9999, 1'b1, 1'b0);
    #1;
    chk("pc_en_stall", {31'd0, pc_enable}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, id_valid}, 32'd1);
      chk("stall_instr", {16'd0, id_instr}, 32'h1234);
      chk("stall_pcp",   id_pc_plus, 32'h21);
    end

    // Stall and flush together: flush wins
    drive(32'h21, 16'h9999, 1'b1, 1'b1);
    #1;
    chk("pc_en_flush", {31'd0, pc_enable}, 32'd1);
    tick();
    chk("sf_valid", {31'd0, id_valid}, 32'd0);
    chk("sf_instr", {16'd0, id_instr}, 32'h1234);
    chk("sf_pcp",   id_pc_plus, 32'h21);

    // Two-word instruction
    drive(32'h40, 16'h8005, 1'b0, 1'b0);
    #1;
    chk("pc_en_w1", {31'd0, pc_enable}, 32'd1);
    tick();
    chk("tw_valid0", {31'd0, id_valid}, 32'd0);
    chk("tw_state",  {31'd0, dbg_state}, 32'd1);
    drive(32'h41, 16'hBEEF, 1'b0, 1'b0);
    #1;
    chk("pc_en_w2", {31'd0, pc_enable}, 32'd1);
    expect_instr(16'h8005, 16'hBEEF, 32'h42);
    tick();
    chk("tw_valid1", {31'd0, id_valid}, 32'd1);

    // One-word straight after a two-word
    drive(32'h50, 16'h0003, 1'b0, 1'b0);
    expect_instr(16'h0003, 16'h0000, 32'h51);
    tick();

    // Stall while waiting for the immediate: hold register must survive
    drive(32'h60, 16'h8111, 1'b0, 1'b0);
    tick();
    drive(32'h61, 16'h2222, 1'b1, 1'b0);
    tick();
    chk("imm_stall_state", {31'd0, dbg_state}, 32'd1);
    chk("imm_stall_valid", {31'd0, id_valid}, 32'd0);
    drive(32'h61, 16'h3333, 1'b0, 1'b0);
    expect_instr(16'h8111, 16'h3333, 32'h62);
    tick();

    // Flush while in IMM abandons the partial instruction
    drive(32'h70, 16'h8001, 1'b0, 1'b0);
    tick();
    drive(32'h71, 16'h5555, 1'b0, 1'b1);
    tick();
    chk("fl_imm_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_imm_state", {31'd0, dbg_state}, 32'd0);
    chk("fl_imm_instr", {16'd0, id_instr}, 32'h8111);
    drive(32'h72, 16'h0007, 1'b0, 1'b0);
    expect_instr(16'h0007, 16'h0000, 32'h73);
    tick();

`ifdef FETCH_PERF_CNT_EN
    // Loads: 1234, 8005, 0003, 8111, 0007.
    // Bubbles: stall+flush, 8005 first word, 8111 first word, 8001 first word, flush.
    chk("perf_instr",  perf_instr_cnt, 32'd5);
    chk("perf_bubble", perf_bubble_cnt, 32'd5);
`endif

    // Asynchronous reset in the middle of IMM
    drive(32'h80, 16'h8ABC, 1'b0, 1'b0);
    tick();
    chk("pre_rst_state", {31'd0, dbg_state}, 32'd1);
    drive(32'h20, 16'h0055, 1'b0, 1'b0);
    tick();
    chk("pre_rst_valid", {31'd0, id_valid}, 32'd1);
    exp_q.push_front({16'h8ABC, 16'h0055, 32'h21});
    drive(32'h30, 16'h8ABC, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_instr", {16'd0, id_instr}, 32'd0);
    chk("arst_imm",   {16'd0, id_imm}, 32'd0);
    chk("arst_pcp",   id_pc_plus, 32'd0);
    chk("arst_state", {31'd0, dbg_state}, 32'd0);
    drive(32'hFFFF_FFFF, 16'h0000, 1'b0, 1'b0);
    #1;
    chk("rst_next_pc_wrap", next_pc, 32'h0);
    chk("rst_imem_addr",    {12'd0, imem_addr}, 32'h000F_FFFF);
    chk("rst_pc_en",        {31'd0, pc_enable}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_perf_instr",  perf_instr_cnt, 32'd0);
    chk("arst_perf_bubble", perf_bubble_cnt, 32'd0);
`endif
    tick();
    rst = 1'b1;

    // First edge after release behaves as FETCH (one-word emitted directly)
    drive(32'h90, 16'h0042, 1'b0, 1'b0);
    expect_instr(16'h0042, 16'h0000, 32'h91);
    tick();
    chk("post_rst_state", {31'd0, dbg_state}, 32'd0);

    // PC wrap on id_pc_plus
    drive(32'hFFFF_FFFF, 16'h0011, 1'b0, 1'b0);
    expect_instr(16'h0011, 16'h0000, 32'h0);
    tick();

    drive(32'h0, 16'h0000, 1'b1, 1'b0);
    repeat (3) tick();

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
